pc_flow_unit: RTL and testbench

- Program-counter and flow-control stage of the single-cycle processor; consumes the ALU ZERO flag and the control unit's branch/jump decode; produces the PC driving instruction fetch.
- Computes sequential PC+4 and branch/jump targets from an 8-bit signed word offset, and selects between them.
- Holds the PC during instruction-memory stalls (BUSYWAIT).
- Keeps saturating counters of taken flow changes and stall cycles for the testbench.

---
 rtl/pc_flow_unit_pkg.sv | 17 +
 rtl/pc_flow_unit_target_adder.sv | 26 ++
 rtl/pc_flow_unit.sv | 120 ++++++++++++
 tb/tb_pc_flow_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_flow_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pc_flow_unit_pkg
// Brief   : State encoding and address-arithmetic constants for the PC stage.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package pc_flow_unit_pkg;

    localparam logic [1:0] c_state_boot  = 2'd0;
    localparam logic [1:0] c_state_run   = 2'd1;
    localparam logic [1:0] c_state_stall = 2'd2;

    localparam int unsigned c_pc_inc       = 4;
    localparam int unsigned c_offset_shift = 2;

endpackage
`default_nettype wire

// File: rtl/pc_flow_unit_target_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pc_target_adder
// Brief   : Sequential PC+4 and word-offset branch/jump target arithmetic.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pc_target_adder
    import pc_flow_unit_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [7:0]          i_offset,
    output logic [PC_WIDTH-1:0] o_pc_plus4,
    output logic [PC_WIDTH-1:0] o_target
);

    logic [PC_WIDTH-1:0] w_offset_ext;

    // Offset counts instruction words, so it becomes a byte displacement after the shift.
    assign w_offset_ext = {{(PC_WIDTH-8){i_offset[7]}}, i_offset};
    assign o_pc_plus4   = i_pc + PC_WIDTH'(c_pc_inc);
    assign o_target     = o_pc_plus4 + (w_offset_ext << c_offset_shift);

endmodule
`default_nettype wire

// File: rtl/pc_flow_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pc_flow_unit
// Brief   : Program counter / flow control with stall hold and event counters.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pc_flow_unit
    import pc_flow_unit_pkg::*;
#(
    parameter int                 PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                 CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 BUSYWAIT,
    input  logic                 JUMP,
    input  logic                 BRANCH,
    input  logic                 BRANCH_NE,
    input  logic                 ZERO,
    input  logic [7:0]           OFFSET,
    output logic [PC_WIDTH-1:0]  PC,
    output logic [PC_WIDTH-1:0]  PC_PLUS4,
    output logic                 TAKEN,
    output logic                 STALLED,
    output logic [CNT_WIDTH-1:0] TAKEN_COUNT,
    output logic [CNT_WIDTH-1:0] STALL_COUNT
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_next;
    logic                 r_stalled;
    logic                 w_stalled_next;
    logic [CNT_WIDTH-1:0] r_taken_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 w_taken_inc;
    logic                 w_stall_inc;
    logic                 w_taken;
    logic [PC_WIDTH-1:0]  w_pc_plus4;
    logic [PC_WIDTH-1:0]  w_target;

    pc_target_adder #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target_adder (
        .i_pc       (r_pc),
        .i_offset   (OFFSET),
        .o_pc_plus4 (w_pc_plus4),
        .o_target   (w_target)
    );

    assign w_taken = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= c_state_boot;
            r_pc      <= RESET_PC;
            r_stalled <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_stalled <= w_stalled_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_stalled_next = r_stalled;
        w_taken_inc    = 1'b0;
        w_stall_inc    = 1'b0;
        case (r_state)
            c_state_boot: begin
                w_state_next   = c_state_run;
                w_stalled_next = 1'b0;
            end
            c_state_run, c_state_stall: begin
                if (BUSYWAIT) begin
                    w_state_next   = c_state_stall;
                    w_stalled_next = 1'b1;
                    w_stall_inc    = 1'b1;
                end else begin
                    w_state_next   = c_state_run;
                    w_stalled_next = 1'b0;
                    w_pc_next      = w_taken ? w_target : w_pc_plus4;
                    w_taken_inc    = w_taken;
                end
            end
            default: begin
                w_state_next   = c_state_run;
                w_stalled_next = 1'b0;
            end
        endcase
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_taken_inc && !(&r_taken_cnt)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (w_stall_inc && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign PC          = r_pc;
    assign PC_PLUS4    = w_pc_plus4;
    assign TAKEN       = w_taken;
    assign STALLED     = r_stalled;
    assign TAKEN_COUNT = r_taken_cnt;
    assign STALL_COUNT = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_flow_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_pc_flow_unit
// Brief   : Scoreboard bench for pc_flow_unit against a behavioural model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pc_flow_unit;

    localparam int PW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          BUSYWAIT;
    logic          JUMP;
    logic          BRANCH;
    logic          BRANCH_NE;
    logic          ZERO;
    logic [7:0]    OFFSET;
    logic [PW-1:0] PC;
    logic [PW-1:0] PC_PLUS4;
    logic          TAKEN;
    logic          STALLED;
    logic [CW-1:0] TAKEN_COUNT;
    logic [CW-1:0] STALL_COUNT;

    pc_flow_unit #(
        .PC_WIDTH  (PW),
        .RESET_PC  (32'h0),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUSYWAIT    (BUSYWAIT),
        .JUMP        (JUMP),
        .BRANCH      (BRANCH),
        .BRANCH_NE   (BRANCH_NE),
        .ZERO        (ZERO),
        .OFFSET      (OFFSET),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .TAKEN       (TAKEN),
        .STALLED     (STALLED),
        .TAKEN_COUNT (TAKEN_COUNT),
        .STALL_COUNT (STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        taken;
        logic        stalled;
        int          tcnt;
        int          scnt;
    } exp_t;

    exp_t q_exp[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    logic [31:0] m_pc      = 32'h0;
    bit          m_boot    = 1'b1;
    bit          m_stalled = 1'b0;
    int          m_tcnt    = 0;
    int          m_scnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: inputs change at the falling edge, the expected
    // visible state for this half-cycle is queued, then the model steps over
    // the coming rising edge.
    task automatic cycle(input bit rst, input bit busy, input bit j, input bit br,
                         input bit bne, input bit z, input logic [7:0] off);
        exp_t        e;
        bit          tk;
        logic [31:0] ext;
        logic [31:0] tgt;
        @(negedge CLK);
        RESET     = rst;
        BUSYWAIT  = busy;
        JUMP      = j;
        BRANCH    = br;
        BRANCH_NE = bne;
        ZERO      = z;
        OFFSET    = off;
        if (!rst) begin
            m_pc      = 32'h0;
            m_boot    = 1'b1;
            m_stalled = 1'b0;
            m_tcnt    = 0;
            m_scnt    = 0;
        end
        tk  = j || (br && z) || (bne && !z);
        ext = {{24{off[7]}}, off};
        tgt = m_pc + 32'd4 + ext * 32'd4;
        e.pc       = m_pc;
        e.pc_plus4 = m_pc + 32'd4;
        e.taken    = tk;
        e.stalled  = m_stalled;
        e.tcnt     = m_tcnt;
        e.scnt     = m_scnt;
        q_exp.push_back(e);
        if (rst) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (busy) begin
                m_stalled = 1'b1;
                if (m_scnt < CMAX) m_scnt++;
            end else begin
                m_stalled = 1'b0;
                m_pc      = tk ? tgt : m_pc + 32'd4;
                if (tk && m_tcnt < CMAX) m_tcnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: checks the DUT away from the rising edge whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("pc",          PC,                 e.pc);
                chk("pc_plus4",    PC_PLUS4,           e.pc_plus4);
                chk("taken",       {31'b0, TAKEN},     {31'b0, e.taken});
                chk("stalled",     {31'b0, STALLED},   {31'b0, e.stalled});
                chk("taken_count", {28'b0, TAKEN_COUNT}, 32'(e.tcnt));
                chk("stall_count", {28'b0, STALL_COUNT}, 32'(e.scnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET     = 1'b0;
        BUSYWAIT  = 1'b0;
        JUMP      = 1'b0;
        BRANCH    = 1'b0;
        BRANCH_NE = 1'b0;
        ZERO      = 1'b0;
        OFFSET    = 8'h00;

        // Reset, release, BOOT then sequential fetch
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        idle(5);

        // Stall at 0x08 with a pending taken beq, then release
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        idle(3);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 0, 1, 8'h01);
        cycle(1, 0, 0, 1, 0, 1, 8'h01);
        idle(1);

        // beq taken at 0x10
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        idle(5);
        cycle(1, 0, 0, 1, 0, 1, 8'h03);
        idle(1);

        // beq not taken at 0x10
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        idle(5);
        cycle(1, 0, 0, 1, 0, 0, 8'h03);
        idle(1);

        // Reach 0x40, bne backwards, return to 0x40, long backward jump
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        idle(1);
        cycle(1, 0, 1, 0, 0, 0, 8'h0F);
        cycle(1, 0, 0, 0, 1, 0, 8'hFE);
        cycle(1, 0, 1, 0, 0, 0, 8'h00);
        cycle(1, 0, 1, 0, 0, 0, 8'h80);
        idle(1);

        // Both branch kinds at once always take
        cycle(1, 0, 0, 1, 1, 0, 8'h05);
        cycle(1, 0, 0, 1, 1, 1, 8'hF0);

        // Saturation of the taken counter
        for (int i = 0; i < 20; i++) cycle(1, 0, 1, 0, 0, 0, 8'h00);

        // Reset asserted mid-stall, then BOOT sequence repeats
        cycle(1, 1, 0, 0, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 0, 0, 8'h00);
        idle(3);

        // Stall counter saturation
        for (int i = 0; i < 18; i++) cycle(1, 1, 1, 0, 0, 0, 8'h10);
        idle(2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 1) == 1,
                  8'($urandom));
        end
        idle(2);

        repeat (3) @(negedge CLK);
        #3;
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
